// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble.
// One result bit is produced per clock under a START/VALID handshake.
// Malformed digits are flagged in a single cycle without shifting, and
// operands above 2^W-1 are flagged with OVF while BINARY keeps value mod 2^W.
module bcd2bin_seq #(
  parameter int W = 10
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic                          START,
  input  logic [W+((W-4)/3)+1-1:0]      BCD,
  output logic                          BUSY,
  output logic                          VALID,
  output logic [W-1:0]                  BINARY,
  output logic                          ERR,
  output logic                          OVF
);

  localparam int BW = W + ((W - 4) / 3) + 1;  // packed BCD operand width
  localparam int NF = BW / 4;                 // nibbles that are complete digits
  localparam int NN = (BW + 3) / 4;           // nibbles including a partial top one
  localparam int PW = 4 * NN;                 // zero-padded shift register width
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   b;
  logic [W-1:0]    r;
  logic [CW-1:0]   cnt;
  logic            err_n;

  logic [PW-1:0]   bcd_pad;
  logic            bcd_bad;
  logic [PW+W-1:0] cat_sh;
  logic [PW-1:0]   b_nxt;
  logic [W-1:0]    r_nxt;
  logic            last_shift;

  // Any complete digit above 9; the partial top nibble cannot exceed 9.
  function automatic logic digit_err(input logic [PW-1:0] x);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < NF; i++) begin
      if (x[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

  // Reverse double-dabble correction: every nibble >= 8 loses 3.
  function automatic logic [PW-1:0] dabble_adjust(input logic [PW-1:0] x);
    logic [PW-1:0] y;
    y = x;
    for (int i = 0; i < NN; i++) begin
      if (x[4*i +: 4] >= 4'd8) y[4*i +: 4] = x[4*i +: 4] - 4'd3;
    end
    return y;
  endfunction

  // Operand padding, digit check and one shift-and-correct step.
  always_comb begin
    bcd_pad    = PW'(BCD);
    bcd_bad    = digit_err(bcd_pad);
    cat_sh     = {b, r} >> 1;
    b_nxt      = dabble_adjust(cat_sh[PW+W-1:W]);
    r_nxt      = cat_sh[W-1:0];
    last_shift = (cnt == CW'(W - 1));
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: invalid operands skip straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = bcd_bad ? DONE : SHIFT;
      SHIFT:   if (last_shift) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Working registers: capture on accepted START, shift once per SHIFT cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      b     <= '0;
      r     <= '0;
      cnt   <= '0;
      err_n <= 1'b0;
    end else begin
      case (state)
        IDLE: if (START) begin
          b     <= bcd_pad;
          r     <= '0;
          cnt   <= '0;
          err_n <= bcd_bad;
        end
        SHIFT: begin
          b   <= b_nxt;
          r   <= r_nxt;
          cnt <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered outputs: results change only on the edge that raises VALID;
  // BUSY covers everything from acceptance through the VALID cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      BUSY   <= 1'b0;
      VALID  <= 1'b0;
      BINARY <= '0;
      ERR    <= 1'b0;
      OVF    <= 1'b0;
    end else begin
      BUSY  <= (state != IDLE) || START;
      VALID <= (state == DONE);
      if (state == DONE) begin
        BINARY <= err_n ? '0 : r;
        OVF    <= err_n ? 1'b0 : (b != '0);
        ERR    <= err_n;
      end
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed self-checking bench for bcd2bin_seq (W=10).
module tb_bcd2bin_seq;

  localparam int W  = 10;
  localparam int BW = 13;

  logic          CLK   = 1'b0;
  logic          RST_N = 1'b1;
  logic          START = 1'b0;
  logic [BW-1:0] BCD   = '0;
  logic          BUSY;
  logic          VALID;
  logic [W-1:0]  BINARY;
  logic          ERR;
  logic          OVF;

  int compared   = 0;
  int mismatched = 0;

  bcd2bin_seq #(.W(W)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .START  (START),
    .BCD    (BCD),
    .BUSY   (BUSY),
    .VALID  (VALID),
    .BINARY (BINARY),
    .ERR    (ERR),
    .OVF    (OVF)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Decimal encoding of a binary value, standing in for the binary-to-BCD block.
  function automatic logic [BW-1:0] to_bcd(input int v);
    logic [15:0] t;
    int          x;
    t = '0;
    x = v;
    for (int d = 0; d < 4; d++) begin
      t[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return t[BW-1:0];
  endfunction

  // Issue START in the current cycle, then wait (bounded) for VALID and
  // check result, flags, START-to-VALID latency and number of BUSY cycles.
  task automatic convert(input string tag, input logic [BW-1:0] v,
                         input int exp_bin, input logic exp_err, input logic exp_ovf,
                         input int exp_lat);
    int lat;
    int busy_n;
    logic timeout;
    START = 1'b1;
    BCD   = v;
    step();
    START   = 1'b0;
    BCD     = BW'($urandom);
    lat     = 1;
    busy_n  = 0;
    timeout = 1'b0;
    forever begin
      if (BUSY) busy_n++;
      if (VALID) break;
      if (lat >= 40) begin
        timeout = 1'b1;
        break;
      end
      step();
      lat++;
    end
    check({tag, " timeout"}, 32'(timeout), 32'd0);
    check({tag, " binary"},  32'(BINARY),  32'(exp_bin));
    check({tag, " err"},     32'(ERR),     32'(exp_err));
    check({tag, " ovf"},     32'(OVF),     32'(exp_ovf));
    check({tag, " latency"}, 32'(lat),     32'(exp_lat));
    check({tag, " busy"},    32'(busy_n),  32'(exp_lat));
  endtask

  initial begin
    int          nvalid;
    logic [W-1:0] first_bin;

    // Reset state
    #2 RST_N = 1'b0;
    #1;
    check("rst busy",   32'(BUSY),   32'd0);
    check("rst valid",  32'(VALID),  32'd0);
    check("rst binary", 32'(BINARY), 32'd0);
    check("rst err",    32'(ERR),    32'd0);
    check("rst ovf",    32'(OVF),    32'd0);
    step();
    step();
    RST_N = 1'b1;
    step();

    // Largest in-range operand, then VALID/BUSY fall and result is held
    convert("c1023", 13'h1023, 1023, 1'b0, 1'b0, 12);
    step();
    check("c1023 valid fall", 32'(VALID),  32'd0);
    check("c1023 busy fall",  32'(BUSY),   32'd0);
    check("c1023 held",       32'(BINARY), 32'd1023);

    // Overflow boundary and large overflow
    convert("c1024", 13'h1024, 0, 1'b0, 1'b1, 12);
    step();
    convert("c1999", 13'h1999, 975, 1'b0, 1'b1, 12);
    step();

    // Invalid digit: fast error path, then a clean zero conversion
    convert("c00A5", 13'h00A5, 0, 1'b1, 1'b0, 2);
    step();
    check("err valid fall", 32'(VALID), 32'd0);
    convert("c0000", 13'h0000, 0, 1'b0, 1'b0, 12);
    step();

    // Round trip of every W-bit value, START issued right after each VALID
    for (int v = 0; v < 1024; v++) begin
      convert("sweep", to_bcd(v), v, 1'b0, 1'b0, 12);
    end
    step();
    check("sweep valid fall", 32'(VALID), 32'd0);
    step();

    // START while BUSY must be ignored
    START = 1'b1;
    BCD   = 13'h0345;
    step();
    nvalid    = 0;
    first_bin = '0;
    for (int i = 0; i < 30; i++) begin
      START = (i < 9);
      BCD   = 13'h0999;
      if (VALID) begin
        nvalid++;
        if (nvalid == 1) first_bin = BINARY;
      end
      step();
    end
    START = 1'b0;
    check("ignore valid count", 32'(nvalid),    32'd1);
    check("ignore binary",      32'(first_bin), 32'd345);

    // Asynchronous reset mid-SHIFT
    START = 1'b1;
    BCD   = 13'h0777;
    step();
    START = 1'b0;
    for (int i = 0; i < 4; i++) step();
    #2 RST_N = 1'b0;
    #1;
    check("midrst busy",   32'(BUSY),   32'd0);
    check("midrst valid",  32'(VALID),  32'd0);
    check("midrst binary", 32'(BINARY), 32'd0);
    check("midrst err",    32'(ERR),    32'd0);
    check("midrst ovf",    32'(OVF),    32'd0);
    step();
    step();
    RST_N = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 15; i++) begin
      if (VALID) nvalid++;
      step();
    end
    check("midrst no valid", 32'(nvalid), 32'd0);
    check("midrst idle",     32'(BUSY),   32'd0);
    convert("c0512", 13'h0512, 512, 1'b0, 1'b0, 12);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
